// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: owns MAR/MDR and sequences SETUP/ACCESS/DONE
// read and write cycles against asynchronous SRAM with active-low strobes.
module mem_access_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus_in,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  output logic [15:0] MDR_out,
  output logic [15:0] MAR_out,
  output logic        R,
  output logic        Busy,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        CE_n,
  output logic        OE_n,
  output logic        WE_n,
  output logic        UB_n,
  output logic        LB_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        op, op_nx;
  logic [15:0] mar, mdr;
  logic        last_access;

  assign last_access  = (state == ACCESS) && (cnt == 4'(WAIT_STATES - 1));
  assign MAR_out      = mar;
  assign MDR_out      = mdr;
  assign ADDR         = {4'b0000, mar};
  assign Data_to_SRAM = mdr;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op;
    case (state)
      IDLE: if (MEM_REQ) begin
        state_nx = SETUP;
        cnt_nx   = '0;
        op_nx    = MEM_WE;
      end
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        cnt_nx = cnt + 4'd1;
        if (last_access) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes, R and Busy are decoded from the next state so they come straight
  // out of flops, aligned with the state register and glitch-free.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= 1'b0;
      mar   <= '0;
      mdr   <= '0;
      CE_n  <= 1'b1;
      OE_n  <= 1'b1;
      WE_n  <= 1'b1;
      UB_n  <= 1'b1;
      LB_n  <= 1'b1;
      R     <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
      if (state == IDLE) begin
        if (LD_MAR) mar <= Bus_in;
        if (LD_MDR) mdr <= Bus_in;
      end
      if (last_access && !op) mdr <= Data_from_SRAM;
      CE_n <= !(state_nx == SETUP || state_nx == ACCESS);
      UB_n <= !(state_nx == SETUP || state_nx == ACCESS);
      LB_n <= !(state_nx == SETUP || state_nx == ACCESS);
      OE_n <= !(state_nx == ACCESS && !op_nx);
      WE_n <= !(state_nx == ACCESS && op_nx);
      R    <= (state_nx == DONE);
      Busy <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: SRAM model, scoreboard checked on each R pulse,
// a vector table of reads/writes and hand-written corner sequences.
module tb_mem_access_ctrl;
  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Bus_in;
  logic        LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
  logic [15:0] MDR_out, MAR_out;
  logic        R, Busy;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic        CE_n, OE_n, WE_n, UB_n, LB_n;

  mem_access_ctrl #(.WAIT_STATES(W)) dut (
    .Clk(Clk), .Reset(Reset), .Bus_in(Bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MDR_out(MDR_out), .MAR_out(MAR_out),
    .R(R), .Busy(Busy), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
    .UB_n(UB_n), .LB_n(LB_n)
  );

  always #5 Clk = ~Clk;

  // asynchronous SRAM model
  logic [15:0] mem [0:65535];
  assign Data_from_SRAM = (!CE_n && !OE_n) ? mem[ADDR[15:0]] : 16'h0000;
  always @(posedge Clk) if (!CE_n && !WE_n) mem[ADDR[15:0]] <= Data_to_SRAM;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  // scoreboard: every R pulse must match one pending access
  always @(negedge Clk) begin
    if (R === 1'b1) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_addr", 32'(ADDR), {12'h0, 4'h0, e.addr});
        if (e.we) chk("wr_mem", 32'(mem[e.addr]), 32'(e.data));
        else      chk("rd_mdr", 32'(MDR_out), 32'(e.data));
      end
    end
  end

  logic noise = 1'b0;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    LD_MAR = 0; LD_MDR = 0; MEM_REQ = 0; MEM_WE = 0; Bus_in = 16'h0;
  endtask

  // Called in cycle 1 (SETUP); follows the access to DONE and one cycle past.
  task automatic wait_done(input logic we, input logic [15:0] addr, input logic [15:0] data);
    int rcyc = 0, oe = 0, wl = 0;
    for (int n = 1; n <= 30; n++) begin
      if (noise) begin
        LD_MAR = 1; LD_MDR = 1; MEM_REQ = 1; MEM_WE = 1; Bus_in = 16'hFFFF;
      end
      chk("busy", 32'(Busy), 32'd1);
      chk("addr", 32'(ADDR), {12'h0, 4'h0, addr});
      if (n == 1) chk("setup_oe_we", 32'({OE_n, WE_n}), 32'b11);
      if (!OE_n) oe++;
      if (!WE_n) begin
        wl++;
        chk("wr_data", 32'(Data_to_SRAM), 32'(data));
      end
      if (R) begin
        rcyc = n;
        chk("done_strobes", 32'({CE_n, OE_n, WE_n, UB_n, LB_n}), 32'h1f);
        break;
      end
      chk("ce_ub_lb", 32'({CE_n, UB_n, LB_n}), 32'd0);
      cyc();
    end
    chk("r_cycle", 32'(rcyc), 32'(2 + W));
    chk("oe_low_cycles", 32'(oe), we ? 32'd0 : 32'(W));
    chk("we_low_cycles", 32'(wl), we ? 32'(W) : 32'd0);
    cyc();
    idle_inputs();
    chk("r_single", 32'(R), 32'd0);
    chk("busy_after", 32'(Busy), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;    // write data, or expected read data
    logic        preset;  // preload model with data before a read
  } vec_t;

  initial begin
    vec_t vt [6];
    vt[0] = '{1'b0, 16'h3000, 16'hBEEF, 1'b1};
    vt[1] = '{1'b1, 16'h1234, 16'hCAFE, 1'b0};
    vt[2] = '{1'b0, 16'h1234, 16'hCAFE, 1'b0};
    vt[3] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0};
    vt[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 16'h5A5A, 1'b1};

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // reset with random inputs
    Reset = 0;
    for (int i = 0; i < 2; i++) begin
      Bus_in = 16'($urandom); LD_MAR = 1'($urandom); LD_MDR = 1'($urandom);
      MEM_REQ = 1'($urandom); MEM_WE = 1'($urandom);
      cyc();
    end
    chk("rst_mar", 32'(MAR_out), 32'd0);
    chk("rst_mdr", 32'(MDR_out), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_strobes", 32'({CE_n, OE_n, WE_n, UB_n, LB_n}), 32'h1f);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_dts", 32'(Data_to_SRAM), 32'd0);
    idle_inputs();
    Reset = 1;
    cyc();

    // vector table: load MAR, then LD_MDR (writes) + MEM_REQ next cycle
    for (int i = 0; i < 6; i++) begin
      if (vt[i].preset) mem[vt[i].addr] = vt[i].data;
      LD_MAR = 1; Bus_in = vt[i].addr;
      cyc();
      LD_MAR = 0; LD_MDR = vt[i].we; Bus_in = vt[i].data;
      MEM_REQ = 1; MEM_WE = vt[i].we;
      sb.push_back('{vt[i].we, vt[i].addr, vt[i].data});
      cyc();
      idle_inputs();
      wait_done(vt[i].we, vt[i].addr, vt[i].data);
      chk("mar_hold", 32'(MAR_out), 32'(vt[i].addr));
      chk("mdr_final", 32'(MDR_out), 32'(vt[i].data));
    end

    // LD_MAR and read request in the same cycle
    mem[16'h0042] = 16'h4242;
    LD_MAR = 1; Bus_in = 16'h0042; MEM_REQ = 1; MEM_WE = 0;
    sb.push_back('{1'b0, 16'h0042, 16'h4242});
    cyc();
    idle_inputs();
    wait_done(1'b0, 16'h0042, 16'h4242);

    // loads and requests hammered throughout an access, including DONE
    mem[16'h0100] = 16'h1111;
    LD_MAR = 1; Bus_in = 16'h0100;
    cyc();
    LD_MAR = 0; LD_MDR = 1; Bus_in = 16'h7E7E; MEM_REQ = 1; MEM_WE = 0;
    sb.push_back('{1'b0, 16'h0100, 16'h1111});
    cyc();
    noise = 1'b1;
    wait_done(1'b0, 16'h0100, 16'h1111);
    noise = 1'b0;
    chk("busy_mar", 32'(MAR_out), 32'h0100);
    chk("busy_mdr", 32'(MDR_out), 32'h1111);
    cyc();
    chk("done_req_dropped", 32'(Busy), 32'd0);

    // reset in the first ACCESS cycle of a write
    LD_MAR = 1; Bus_in = 16'h0300;
    cyc();
    LD_MAR = 0; LD_MDR = 1; Bus_in = 16'h7777; MEM_REQ = 1; MEM_WE = 1;
    cyc();
    idle_inputs();
    cyc();
    chk("midrst_we_low", 32'(WE_n), 32'd0);
    Reset = 0;
    cyc();
    chk("midrst_we", 32'(WE_n), 32'd1);
    chk("midrst_ce", 32'(CE_n), 32'd1);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_mar", 32'(MAR_out), 32'd0);
    chk("midrst_r", 32'(R), 32'd0);
    Reset = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst_idle", 32'({R, Busy}), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
